// File: rtl/ddr5_dfi_write_issuer.sv
// DFI phase-0 write issuer: turns WR/MRW requests into two-cycle DDR5 commands
// and drives write-data beats at the programmed write latency (1:1 ratio).
module ddr5_dfi_write_issuer #(
  parameter int pDRAM_SIZE = 4,
  parameter int pNUM_RANK  = 1,
  parameter int pWL        = 4,
  parameter int pMRD       = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_mrw_i,
  input  logic                      req_bl32_i,
  input  logic [pNUM_RANK-1:0]      req_rank_i,
  input  logic [13:0]               req_ca0_i,
  input  logic [13:0]               req_ca1_i,
  input  logic                      wd_valid_i,
  output logic                      wd_ready_o,
  input  logic [2*pDRAM_SIZE-1:0]   wd_data_i,
  input  logic [pDRAM_SIZE/4-1:0]   wd_mask_i,
  output logic [pNUM_RANK-1:0]      dfi_cs_n_p0,
  output logic [pNUM_RANK-1:0]      dfi_reset_n_p0,
  output logic [13:0]               dfi_address_p0,
  output logic                      dfi_wrdata_en_p0,
  output logic [2*pDRAM_SIZE-1:0]   dfi_wrdata_p0,
  output logic [pDRAM_SIZE/4-1:0]   dfi_wrdata_mask_p0,
  output logic                      err_underflow_o,
  output logic [2:0]                dbg_state_o
);

  // Handshake: a request transfers on a rising edge where req_valid_i and
  // req_ready_o are both high; a data beat transfers where wd_ready_o is high
  // (wd_valid_i low at that edge yields a masked, flagged beat).

  localparam int WAIT_MAX = (pMRD > pWL) ? pMRD : pWL;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int DW       = 2 * pDRAM_SIZE;
  localparam int MW       = pDRAM_SIZE / 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD1     = 3'd1,
    S_WL_WAIT  = 3'd2,
    S_DATA     = 3'd3,
    S_MRD_WAIT = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [4:0]          r_beat_cnt;
  logic [4:0]          w_beat_nxt;
  logic                r_mrw;
  logic                r_bl32;
  logic [13:0]         r_ca1;

  logic                r_req_ready;
  logic                r_wd_ready;
  logic [pNUM_RANK-1:0] r_cs_n;
  logic [pNUM_RANK-1:0] r_reset_n;
  logic [13:0]         r_addr;
  logic                r_en;
  logic [DW-1:0]       r_data;
  logic [MW-1:0]       r_mask;
  logic                r_uf_beat;
  logic                r_err;

  logic                w_accept;
  logic [pNUM_RANK-1:0] w_cs_nxt;
  logic [13:0]         w_addr_nxt;
  logic                w_en_nxt;
  logic [DW-1:0]       w_data_nxt;
  logic [MW-1:0]       w_mask_nxt;
  logic                w_uf_nxt;
  logic                w_req_ready_nxt;
  logic                w_wd_ready_nxt;
  logic [4:0]          w_last_beat;

  assign w_accept    = (r_state == S_IDLE) && r_req_ready && req_valid_i;
  assign w_last_beat = r_bl32 ? 5'd15 : 5'd7;

  // Each state computes the outputs shown in the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_beat_nxt  = r_beat_cnt;
    w_cs_nxt    = '1;
    w_addr_nxt  = '0;
    w_en_nxt    = 1'b0;
    w_data_nxt  = '0;
    w_mask_nxt  = '0;
    w_uf_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CMD1;
          w_cs_nxt    = ~req_rank_i;
          w_addr_nxt  = {req_ca0_i[13:5], (req_mrw_i ? 5'b00101 : 5'b01101)};
        end
      end
      S_CMD1: begin
        w_addr_nxt = r_ca1;
        if (r_mrw) begin
          w_state_nxt = S_MRD_WAIT;
          w_wait_nxt  = WAIT_W'(pMRD - 1);
        end else if (pWL == 2) begin
          w_state_nxt = S_DATA;
          w_beat_nxt  = 5'd0;
        end else begin
          w_state_nxt = S_WL_WAIT;
          w_wait_nxt  = WAIT_W'(pWL - 3);
        end
      end
      S_WL_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = S_DATA;
          w_beat_nxt  = 5'd0;
        end else begin
          w_wait_nxt = r_wait_cnt - 1'b1;
        end
      end
      S_DATA: begin
        w_en_nxt = 1'b1;
        if (wd_valid_i) begin
          w_data_nxt = wd_data_i;
          w_mask_nxt = wd_mask_i;
        end else begin
          w_mask_nxt = '1;
          w_uf_nxt   = 1'b1;
        end
        if (r_beat_cnt == w_last_beat) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_beat_nxt = r_beat_cnt + 5'd1;
        end
      end
      S_MRD_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wait_nxt = r_wait_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Ready only rises after a full idle cycle, so a finished burst leaves one
    // quiet cycle before the next acceptance.
    w_req_ready_nxt = (r_state == S_IDLE) && (w_state_nxt == S_IDLE) && enable_i;
    w_wd_ready_nxt  = (w_state_nxt == S_DATA);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_beat_cnt  <= 5'd0;
      r_mrw       <= 1'b0;
      r_bl32      <= 1'b0;
      r_ca1       <= '0;
      r_req_ready <= 1'b0;
      r_wd_ready  <= 1'b0;
      r_cs_n      <= '1;
      r_reset_n   <= '0;
      r_addr      <= '0;
      r_en        <= 1'b0;
      r_data      <= '0;
      r_mask      <= '0;
      r_uf_beat   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_beat_cnt  <= w_beat_nxt;
      if (w_accept) begin
        r_mrw  <= req_mrw_i;
        r_bl32 <= req_bl32_i;
        r_ca1  <= req_ca1_i;
      end
      r_req_ready <= w_req_ready_nxt;
      r_wd_ready  <= w_wd_ready_nxt;
      r_cs_n      <= w_cs_nxt;
      r_reset_n   <= '1;
      r_addr      <= w_addr_nxt;
      r_en        <= w_en_nxt;
      r_data      <= w_data_nxt;
      r_mask      <= w_mask_nxt;
      r_uf_beat   <= w_uf_nxt;
      // Error flag rises the cycle after the empty beat is driven.
      r_err       <= r_err | r_uf_beat;
    end
  end

  assign req_ready_o        = r_req_ready;
  assign wd_ready_o         = r_wd_ready;
  assign dfi_cs_n_p0        = r_cs_n;
  assign dfi_reset_n_p0     = r_reset_n;
  assign dfi_address_p0     = r_addr;
  assign dfi_wrdata_en_p0   = r_en;
  assign dfi_wrdata_p0      = r_data;
  assign dfi_wrdata_mask_p0 = r_mask;
  assign err_underflow_o    = r_err;
  assign dbg_state_o        = r_state;

endmodule

// File: tb/tb_ddr5_dfi_write_issuer.sv
// Directed bench for ddr5_dfi_write_issuer with default parameters (x4, 1 rank,
// WL=4, MRD=8); per-cycle captures are compared against hand-derived timelines.
module tb_ddr5_dfi_write_issuer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_mrw_i;
  logic        req_bl32_i;
  logic [0:0]  req_rank_i;
  logic [13:0] req_ca0_i;
  logic [13:0] req_ca1_i;
  logic        wd_valid_i;
  logic        wd_ready_o;
  logic [7:0]  wd_data_i;
  logic [0:0]  wd_mask_i;
  logic [0:0]  dfi_cs_n_p0;
  logic [0:0]  dfi_reset_n_p0;
  logic [13:0] dfi_address_p0;
  logic        dfi_wrdata_en_p0;
  logic [7:0]  dfi_wrdata_p0;
  logic [0:0]  dfi_wrdata_mask_p0;
  logic        err_underflow_o;
  logic [2:0]  dbg_state_o;

  int n_total = 0;
  int n_bad   = 0;

  logic        cap_cs   [40];
  logic        cap_rstn [40];
  logic [13:0] cap_addr [40];
  logic        cap_en   [40];
  logic [7:0]  cap_data [40];
  logic        cap_mask [40];
  logic        cap_wdr  [40];
  logic        cap_rr   [40];
  logic        cap_err  [40];

  ddr5_dfi_write_issuer dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .enable_i           (enable_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_mrw_i          (req_mrw_i),
    .req_bl32_i         (req_bl32_i),
    .req_rank_i         (req_rank_i),
    .req_ca0_i          (req_ca0_i),
    .req_ca1_i          (req_ca1_i),
    .wd_valid_i         (wd_valid_i),
    .wd_ready_o         (wd_ready_o),
    .wd_data_i          (wd_data_i),
    .wd_mask_i          (wd_mask_i),
    .dfi_cs_n_p0        (dfi_cs_n_p0),
    .dfi_reset_n_p0     (dfi_reset_n_p0),
    .dfi_address_p0     (dfi_address_p0),
    .dfi_wrdata_en_p0   (dfi_wrdata_en_p0),
    .dfi_wrdata_p0      (dfi_wrdata_p0),
    .dfi_wrdata_mask_p0 (dfi_wrdata_mask_p0),
    .err_underflow_o    (err_underflow_o),
    .dbg_state_o        (dbg_state_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Driver: issues one request, then records ncyc cycles starting at word0 (c=0)
  // while streaming source data dbase + idx*dstep.
  task automatic run_op(input bit mrw, input bit bl32, input logic [13:0] ca0,
                        input logic [13:0] ca1, input bit drop3, input int rst_at,
                        input logic [7:0] dbase, input int dstep, input int ncyc);
    int waitc;
    int rdy_cnt;
    int idx;
    waitc = 0; rdy_cnt = 0; idx = 0;
    while (req_ready_o !== 1'b1 && waitc < 50) begin
      tick();
      waitc++;
    end
    chk("accept_ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_mrw_i = mrw; req_bl32_i = bl32;
    req_ca0_i = ca0; req_ca1_i = ca1; wd_valid_i = 1'b1; wd_data_i = dbase;
    tick();
    // Scramble the request fields: the block must use its latched copy.
    req_valid_i = 1'b0; req_mrw_i = ~mrw; req_bl32_i = ~bl32;
    req_ca0_i = ~ca0; req_ca1_i = ~ca1;
    for (int c = 0; c < ncyc; c++) begin
      cap_cs[c] = dfi_cs_n_p0[0]; cap_rstn[c] = dfi_reset_n_p0[0];
      cap_addr[c] = dfi_address_p0; cap_en[c] = dfi_wrdata_en_p0;
      cap_data[c] = dfi_wrdata_p0; cap_mask[c] = dfi_wrdata_mask_p0[0];
      cap_wdr[c] = wd_ready_o; cap_rr[c] = req_ready_o; cap_err[c] = err_underflow_o;
      rst_i = (c == rst_at);
      wd_valid_i = !(drop3 && wd_ready_o && rdy_cnt == 3);
      wd_data_i = dbase + 8'(idx * dstep);
      if (wd_ready_o) begin
        if (wd_valid_i) idx++;
        rdy_cnt++;
      end
      tick();
    end
    rst_i = 1'b0;
  endtask

  // Scoreboard for a WR: word0 at c=0, word1 at c=1, beats at c=4..4+n-1,
  // wd_ready at c=3..n+2, req_ready at c=n+4.
  task automatic check_wr(input string nm, input bit bl32, input logic [13:0] w0,
                          input logic [13:0] w1, input bit drop3, input logic [7:0] dbase,
                          input int dstep, input int err_from, input int ncyc);
    int n;
    int k;
    int sidx;
    logic [13:0] e_addr;
    logic [7:0]  e_data;
    logic        e_mask;
    logic        e_beat;
    n = bl32 ? 16 : 8;
    for (int c = 0; c < ncyc; c++) begin
      e_addr = (c == 0) ? w0 : ((c == 1) ? w1 : 14'h0);
      k = c - 4;
      e_beat = (k >= 0) && (k < n);
      e_data = 8'h00; e_mask = 1'b0;
      if (e_beat) begin
        if (drop3 && k == 3) begin
          e_mask = 1'b1;
        end else begin
          sidx = (drop3 && k > 3) ? k - 1 : k;
          e_data = dbase + 8'(sidx * dstep);
        end
      end
      chk($sformatf("%s cs@%0d", nm, c), 32'(cap_cs[c]), (c == 0) ? 32'd0 : 32'd1);
      chk($sformatf("%s addr@%0d", nm, c), 32'(cap_addr[c]), 32'(e_addr));
      chk($sformatf("%s en@%0d", nm, c), 32'(cap_en[c]), 32'(e_beat));
      chk($sformatf("%s data@%0d", nm, c), 32'(cap_data[c]), 32'(e_data));
      chk($sformatf("%s mask@%0d", nm, c), 32'(cap_mask[c]), 32'(e_mask));
      chk($sformatf("%s wdrdy@%0d", nm, c), 32'(cap_wdr[c]), 32'(c >= 3 && c <= n + 2));
      chk($sformatf("%s reqrdy@%0d", nm, c), 32'(cap_rr[c]), 32'(c >= n + 4));
      chk($sformatf("%s err@%0d", nm, c), 32'(cap_err[c]), 32'(err_from >= 0 && c >= err_from));
      chk($sformatf("%s rstn@%0d", nm, c), 32'(cap_rstn[c]), 32'd1);
    end
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; req_valid_i = 1'b0; req_mrw_i = 1'b0;
    req_bl32_i = 1'b0; req_rank_i = 1'b1; req_ca0_i = '0; req_ca1_i = '0;
    wd_valid_i = 1'b0; wd_data_i = '0; wd_mask_i = '0;
    tick();
    chk("rst cs", 32'(dfi_cs_n_p0), 32'd1);
    chk("rst addr", 32'(dfi_address_p0), 32'd0);
    chk("rst en", 32'(dfi_wrdata_en_p0), 32'd0);
    chk("rst data", 32'(dfi_wrdata_p0), 32'd0);
    chk("rst mask", 32'(dfi_wrdata_mask_p0), 32'd0);
    chk("rst rstn", 32'(dfi_reset_n_p0), 32'd0);
    chk("rst reqrdy", 32'(req_ready_o), 32'd0);
    chk("rst wdrdy", 32'(wd_ready_o), 32'd0);
    chk("rst err", 32'(err_underflow_o), 32'd0);
    chk("rst state", 32'(dbg_state_o), 32'd0);
    rst_i = 1'b0;
    tick();
    chk("post rst reqrdy", 32'(req_ready_o), 32'd1);
    chk("post rst rstn", 32'(dfi_reset_n_p0), 32'd1);

    // BL16 write, constant AA data
    run_op(1'b0, 1'b0, 14'h000D, 14'h001C, 1'b0, -1, 8'hAA, 0, 14);
    check_wr("bl16", 1'b0, 14'h000D, 14'h001C, 1'b0, 8'hAA, 0, -1, 14);

    // BL32 write, ascending source data; word0 low bits forced to 01101
    run_op(1'b0, 1'b1, 14'h0A00, 14'h001C, 1'b0, -1, 8'h10, 1, 22);
    check_wr("bl32", 1'b1, 14'h0A0D, 14'h001C, 1'b0, 8'h10, 1, -1, 22);

    // MRW: ca0 0105 -> word0 0105, ca1 0090; ready back at c=10
    run_op(1'b1, 1'b0, 14'h0105, 14'h0090, 1'b0, -1, 8'h77, 1, 12);
    chk("mrw w0", 32'(cap_addr[0]), 32'h0105);
    chk("mrw cs0", 32'(cap_cs[0]), 32'd0);
    chk("mrw w1", 32'(cap_addr[1]), 32'h0090);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("mrw en@%0d", c), 32'(cap_en[c]), 32'd0);
      chk($sformatf("mrw wdrdy@%0d", c), 32'(cap_wdr[c]), 32'd0);
      chk($sformatf("mrw reqrdy@%0d", c), 32'(cap_rr[c]), 32'(c >= 10));
    end

    // Underflow on beat 3 of a BL16 write
    run_op(1'b0, 1'b0, 14'h000D, 14'h001C, 1'b1, -1, 8'h30, 1, 14);
    check_wr("uflow", 1'b0, 14'h000D, 14'h001C, 1'b1, 8'h30, 1, 8, 14);

    // Reset at beat 5 (c=9) of a BL32 write
    run_op(1'b0, 1'b1, 14'h000D, 14'h001C, 1'b0, 9, 8'h50, 1, 14);
    chk("rmid beat5 en", 32'(cap_en[9]), 32'd1);
    chk("rmid beat5 data", 32'(cap_data[9]), 32'h55);
    chk("rmid err before", 32'(cap_err[9]), 32'd1);
    chk("rmid en", 32'(cap_en[10]), 32'd0);
    chk("rmid cs", 32'(cap_cs[10]), 32'd1);
    chk("rmid rstn", 32'(cap_rstn[10]), 32'd0);
    chk("rmid wdrdy", 32'(cap_wdr[10]), 32'd0);
    chk("rmid err", 32'(cap_err[10]), 32'd0);
    chk("rmid data", 32'(cap_data[10]), 32'd0);
    chk("rmid reqrdy after", 32'(cap_rr[11]), 32'd1);
    chk("rmid rstn after", 32'(cap_rstn[11]), 32'd1);
    for (int c = 11; c < 14; c++) begin
      chk($sformatf("rmid en@%0d", c), 32'(cap_en[c]), 32'd0);
    end
    run_op(1'b0, 1'b0, 14'h000D, 14'h001C, 1'b0, -1, 8'h60, 1, 14);
    check_wr("after rst", 1'b0, 14'h000D, 14'h001C, 1'b0, 8'h60, 1, -1, 14);

    // Back-to-back BL16 with req_valid held high: second word0 at c=13
    begin
      int waitc;
      waitc = 0;
      while (req_ready_o !== 1'b1 && waitc < 50) begin
        tick();
        waitc++;
      end
      chk("b2b ready", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1; req_mrw_i = 1'b0; req_bl32_i = 1'b0;
      req_ca0_i = 14'h000D; req_ca1_i = 14'h001C; wd_valid_i = 1'b1; wd_data_i = 8'hAA;
      tick();
      for (int c = 0; c < 27; c++) begin
        chk($sformatf("b2b cs@%0d", c), 32'(dfi_cs_n_p0), (c == 0 || c == 13) ? 32'd0 : 32'd1);
        chk($sformatf("b2b en@%0d", c), 32'(dfi_wrdata_en_p0),
            32'((c >= 4 && c <= 11) || (c >= 17 && c <= 24)));
        if (c >= 13) req_valid_i = 1'b0;
        tick();
      end
    end

    // enable low: no acceptance while idle
    enable_i = 1'b0;
    tick();
    req_valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("dis reqrdy@%0d", c), 32'(req_ready_o), 32'd0);
      chk($sformatf("dis cs@%0d", c), 32'(dfi_cs_n_p0), 32'd1);
    end
    req_valid_i = 1'b0;
    enable_i = 1'b1;
    tick();
    tick();
    chk("en back reqrdy", 32'(req_ready_o), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
